// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch queue sitting in front of a combinational
// instruction memory. Fetches one word per cycle into a small circular queue,
// stops at a halt opcode, and supports redirect (flush) and a global freeze.
module if_prefetch #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 12,
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                delay,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                br_valid,
  input  logic [ADDR_W+1:0]   br_addr,
  output logic [DATA_W-1:0]   ins,
  output logic [ADDR_W+1:0]   ins_pc,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic                over
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = ADDR_W + 2;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] word_d [DEPTH];
  logic [PC_W-1:0]   epc_q  [DEPTH];
  logic [PC_W-1:0]   epc_d  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halt_seen_q, halt_seen_d;
  logic              over_q, over_d;

  logic empty, full, pop, is_halt, fetch, push;

  // Handshake and fetch qualification, all from registered state plus inputs.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    pop     = !empty && ins_ready && !delay;
    is_halt = (mem_data[DATA_W-1:DATA_W-4] == HALT_OP);
    fetch   = !delay && !br_valid && !halt_seen_q && !over_q && (!full || pop);
    push    = fetch && !is_halt;
  end

  // Outputs come only from the queue registers; an empty queue shows zeros.
  assign mem_addr  = pc_q[PC_W-1:2];
  assign ins_valid = !empty;
  assign ins       = empty ? '0 : word_q[rd_ptr_q];
  assign ins_pc    = empty ? '0 : epc_q[rd_ptr_q];
  assign over      = over_q;

  // Next-state: freeze holds everything, a finished program ignores redirects,
  // a redirect flushes the queue ahead of any push/pop, otherwise stream.
  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    halt_seen_d = halt_seen_q;
    over_d      = over_q;
    for (int i = 0; i < DEPTH; i++) begin
      word_d[i] = word_q[i];
      epc_d[i]  = epc_q[i];
    end

    if (!delay && !over_q) begin
      if (br_valid) begin
        pc_d        = {br_addr[PC_W-1:2], 2'b00};
        rd_ptr_d    = '0;
        wr_ptr_d    = '0;
        count_d     = '0;
        halt_seen_d = 1'b0;
      end else begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
          word_d[wr_ptr_q] = mem_data;
          epc_d[wr_ptr_q]  = pc_q;
          wr_ptr_d         = wr_ptr_q + PTR_W'(1);
          pc_d             = pc_q + PC_W'(4);
        end
        if (fetch && is_halt) begin
          halt_seen_d = 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (halt_seen_q && empty) begin
          over_d = 1'b1;
        end
      end
    end
  end

  // Control state register; reset applies only when not frozen.
  always_ff @(posedge clk) begin
    if (reset && !delay) begin
      pc_q        <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      halt_seen_q <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      halt_seen_q <= halt_seen_d;
      over_q      <= over_d;
    end
  end

  // Queue storage; contents are masked by count, so they need no reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        word_q[gi] <= word_d[gi];
        epc_q[gi]  <= epc_d[gi];
      end
    end
  endgenerate

endmodule

// File: tb/tb_if_prefetch.sv
// Directed, table-driven bench for if_prefetch with a behavioural memory.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset, delay, br_valid, ins_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic [13:0] br_addr;
  logic [31:0] ins;
  logic [13:0] ins_pc;
  logic        ins_valid, over;

  logic [31:0] mem [0:4095];
  assign mem_data = mem[mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  if_prefetch #(.DATA_W(32), .ADDR_W(12), .DEPTH(4), .HALT_OP(4'b1111)) dut (
    .clk(clk), .reset(reset), .delay(delay), .mem_addr(mem_addr),
    .mem_data(mem_data), .br_valid(br_valid), .br_addr(br_addr),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .over(over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, dly, rdy, brv;
    logic [13:0] bra;
    logic        vld;
    logic [31:0] ins;
    logic [13:0] pc;
    logic        ovr;
    logic [11:0] maddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, dly, rdy, brv, input logic [13:0] bra,
                     input logic vld, input logic [31:0] w, input logic [13:0] pc,
                     input logic ovr, input logic [11:0] maddr);
    vec_t v;
    v.rst = rst; v.dly = dly; v.rdy = rdy; v.brv = brv; v.bra = bra;
    v.vld = vld; v.ins = w; v.pc = pc; v.ovr = ovr; v.maddr = maddr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input logic rst, dly, rdy, brv, input logic [13:0] bra);
    reset = rst; delay = dly; ins_ready = rdy; br_valid = brv; br_addr = bra;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] w,
                         input logic [13:0] pc, input logic ovr, input logic [11:0] maddr);
    chk({tag, ".ins_valid"}, {31'd0, ins_valid}, {31'd0, vld});
    chk({tag, ".ins"},       ins, w);
    chk({tag, ".ins_pc"},    {18'd0, ins_pc}, {18'd0, pc});
    chk({tag, ".over"},      {31'd0, over}, {31'd0, ovr});
    chk({tag, ".mem_addr"},  {20'd0, mem_addr}, {20'd0, maddr});
    $display("txn %s: vld=%0b ins=%h pc=%h over=%0b maddr=%0d",
             tag, ins_valid, ins, ins_pc, over, mem_addr);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    reset = 1'b1; delay = 1'b0; ins_ready = 1'b0; br_valid = 1'b0; br_addr = '0;

    //   rst dly rdy brv bra       vld ins            pc        ovr maddr
    // streaming after reset
    add(1, 0, 1, 0, 14'h0,    0, 32'h0,          14'h0,    0, 12'd0);
    add(0, 0, 1, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd1);
    add(0, 0, 1, 0, 14'h0,    1, 32'h2222_2222,  14'h4,    0, 12'd2);
    add(0, 0, 1, 0, 14'h0,    1, 32'h3333_3333,  14'h8,    0, 12'd3);
    // back-pressure from reset: fills to 4, mem_addr frozen at 4
    add(1, 0, 0, 0, 14'h0,    0, 32'h0,          14'h0,    0, 12'd0);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd1);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd2);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd3);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd4);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd4);
    add(0, 0, 0, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd4);
    // drain in order while refilling
    add(0, 0, 1, 0, 14'h0,    1, 32'h2222_2222,  14'h4,    0, 12'd5);
    add(0, 0, 1, 0, 14'h0,    1, 32'h3333_3333,  14'h8,    0, 12'd6);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0003,  14'hC,    0, 12'd7);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0004,  14'h10,   0, 12'd8);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0005,  14'h14,   0, 12'd9);
    // redirect on a full queue, then unaligned redirect
    add(0, 0, 1, 1, 14'h40,   0, 32'h0,          14'h0,    0, 12'd16);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0010,  14'h40,   0, 12'd17);
    add(0, 0, 1, 1, 14'h43,   0, 32'h0,          14'h0,    0, 12'd16);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0010,  14'h40,   0, 12'd17);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0011,  14'h44,   0, 12'd18);
    // freeze with reset and redirect pulsed inside it
    add(1, 1, 1, 0, 14'h0,    1, 32'hA000_0011,  14'h44,   0, 12'd18);
    add(0, 1, 1, 1, 14'h80,   1, 32'hA000_0011,  14'h44,   0, 12'd18);
    add(0, 1, 1, 0, 14'h0,    1, 32'hA000_0011,  14'h44,   0, 12'd18);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0012,  14'h48,   0, 12'd19);
    // PC wrap at the top of the address space
    add(0, 0, 1, 1, 14'h3FFC, 0, 32'h0,          14'h0,    0, 12'd4095);
    add(0, 0, 1, 0, 14'h0,    1, 32'hA000_0FFF,  14'h3FFC, 0, 12'd0);
    add(0, 0, 1, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd1);
    // reset wins over a same-cycle redirect
    add(1, 0, 1, 1, 14'h40,   0, 32'h0,          14'h0,    0, 12'd0);
    add(0, 0, 1, 0, 14'h0,    1, 32'h1111_1111,  14'h0,    0, 12'd1);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].dly, vq[i].rdy, vq[i].brv, vq[i].bra);
      chk_out($sformatf("vec%0d", i), vq[i].vld, vq[i].ins, vq[i].pc, vq[i].ovr, vq[i].maddr);
    end

    // halt at byte 0x8: two words delivered, halt never shown, over sticky
    mem[2] = 32'hF000_0000;
    cyc(1, 0, 1, 0, 14'h0);  chk_out("halt_rst",  0, 32'h0,         14'h0, 0, 12'd0);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("halt_w0",   1, 32'h1111_1111, 14'h0, 0, 12'd1);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("halt_w1",   1, 32'h2222_2222, 14'h4, 0, 12'd2);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("halt_seen", 0, 32'h0,         14'h0, 0, 12'd2);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("halt_over", 0, 32'h0,         14'h0, 1, 12'd2);
    cyc(0, 0, 1, 1, 14'h20); chk_out("over_br",   0, 32'h0,         14'h0, 1, 12'd2);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("over_hold", 0, 32'h0,         14'h0, 1, 12'd2);
    cyc(1, 0, 1, 0, 14'h0);  chk_out("over_rst",  0, 32'h0,         14'h0, 0, 12'd0);

    // halt fetched while words are still queued, then redirect to 0x20
    cyc(0, 0, 0, 0, 14'h0);  chk_out("hb_f0",     1, 32'h1111_1111, 14'h0,  0, 12'd1);
    cyc(0, 0, 0, 0, 14'h0);  chk_out("hb_f1",     1, 32'h1111_1111, 14'h0,  0, 12'd2);
    cyc(0, 0, 0, 0, 14'h0);  chk_out("hb_halt",   1, 32'h1111_1111, 14'h0,  0, 12'd2);
    cyc(0, 0, 0, 0, 14'h0);  chk_out("hb_wait",   1, 32'h1111_1111, 14'h0,  0, 12'd2);
    cyc(0, 0, 0, 1, 14'h20); chk_out("hb_br",     0, 32'h0,         14'h0,  0, 12'd8);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("hb_r0",     1, 32'hA000_0008, 14'h20, 0, 12'd9);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("hb_r1",     1, 32'hA000_0009, 14'h24, 0, 12'd10);
    cyc(0, 0, 1, 0, 14'h0);  chk_out("hb_r2",     1, 32'hA000_000A, 14'h28, 0, 12'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
Parameters:
REQ-001 DATA_W, default 32: instruction width in bits; DATA_W SHALL be at least 8.
REQ-002 ADDR_W, default 12: word-address width into instruction memory.
REQ-003 DEPTH, default 4: prefetch queue entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-004 HALT_OP, default 4'b1111: halt opcode, matched against bits [DATA_W-1:DATA_W-4].
Ports:
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 delay  in  1  global freeze: when high, every register SHALL hold its value.
REQ-008 mem_addr  out  ADDR_W  word address to combinational instruction memory; equals PC[ADDR_W+1:2].
REQ-009 mem_data  in  DATA_W  instruction word at mem_addr, valid in the same cycle.
REQ-010 br_valid  in  1  redirect request.
REQ-011 br_addr  in  ADDR_W+2  byte address of the redirect target.
REQ-012 ins  out  DATA_W  queue-head instruction; 0 when the queue is empty.
REQ-013 ins_pc  out  ADDR_W+2  byte address of ins; 0 when the queue is empty.
REQ-014 ins_valid  out  1  queue not empty.
REQ-015 ins_ready  in  1  consumer accepts ins.
REQ-016 over  out  1  program finished; sticky until reset.

Function
REQ-017 Internal state: PC (ADDR_W+2 bits), circular queue of DEPTH {word, pc} entries, read/write pointers, occupancy count (log2(DEPTH)+1 bits), halt_seen flag, over flag.
REQ-018 pop = ins_valid && ins_ready && !delay; the head entry SHALL leave the queue at that clock edge.
REQ-019 is_halt = (mem_data[DATA_W-1:DATA_W-4] == HALT_OP).
REQ-020 fetch = !delay && !br_valid && !halt_seen && !over && (count < DEPTH || pop).
REQ-021 fetch && !is_halt: push {mem_data, PC} and advance PC by 4 (modulo 2^(ADDR_W+2), wrapping to 0).
REQ-022 fetch && is_halt: set halt_seen; no push; PC holds; the halt word SHALL never appear on ins.
REQ-023 Queue full and no pop: no fetch; PC and mem_addr hold (back-pressure).
REQ-024 Push and pop in the same cycle: count unchanged; both pointers advance.
REQ-025 br_valid && !delay: flush all entries (count=0, pointers=0), PC <= br_addr with bits [1:0] forced to 0, clear halt_seen; no push that cycle; priority over push and pop; a same-cycle pop still counts as accepted by the consumer.
REQ-026 over SHALL be set at the edge where halt_seen is 1, count is 0 and br_valid is 0; once set, only reset clears it.
REQ-027 br_valid while over=1: ignored; PC and queue hold.
REQ-028 Fetch-to-ins latency: a word fetched at edge N appears on ins after edge N if the queue was empty.
REQ-029 ins, ins_pc and ins_valid SHALL be driven from registered queue state only, with no combinational path from mem_data or ins_ready.
REQ-030 Zero-latency bypass SHALL NOT be implemented.

Reset
REQ-031 reset=1 at an edge with delay=0: PC=0, count=0, pointers=0, halt_seen=0, over=0; outputs ins=0, ins_pc=0, ins_valid=0, over=0.
REQ-032 reset=1 together with delay=1: the freeze wins and state holds. This matches the existing pipeline's freeze semantics.
REQ-033 Reset during a fetch or branch cycle: reset wins over all other updates.
REQ-034 The first fetch SHALL occur at the first edge after reset deasserts.

Verification
REQ-035 Memory words 0x11111111, 0x22222222, 0x33333333, ins_ready=1 after reset -> ins_pc 0x0, 0x4, 0x8 with matching words on consecutive cycles, ins_valid=1 from the first post-reset edge.
REQ-036 ins_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4, mem_addr frozen at 4; on ins_ready=1, entries drain in order, none lost or duplicated.
REQ-037 Queue holding pc 0x0 to 0xC, br_valid=1 with br_addr=0x40 -> next cycle ins_valid=0; following cycle ins_pc=0x40; br_addr=0x43 also yields fetch from 0x40.
REQ-038 Word 0xF0000000 at byte 0x8, ins_ready=1 -> 0x0 and 0x4 delivered, halt word never output, over=1 the edge after the queue empties, then stays 1; a subsequent br_valid has no effect.
REQ-039 Halt at 0x8 fetched while the instruction at 0x4 is still queued, then br_valid to 0x20 -> halt_seen cleared, over stays 0, fetch resumes at 0x20.
REQ-040 delay=1 for 3 cycles in mid-stream, with br_valid and reset pulsed during the freeze -> all outputs unchanged until delay falls.
